bidir_shift_feeder: RTL and testbench
=====================================

# bidir_shift_feeder

Upstream serializer for the bidirectional shift register. Accepts a parallel word and a direction over a valid/ready handshake. Drives the register's `en`, `dir` and `d` inputs for exactly SIZE clocks, ordering the bits so that the register's `out` equals the accepted word after the frame, in either direction. It then pulses `done` for one cycle.

## Interface
- SIZE, 16, word width; must match the downstream register's `size`; legal range is 2 or greater.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  a word is offered on `in_data`/`in_dir`.
- in_ready  out  1  feeder can accept a word this cycle.
- in_data  in  SIZE  parallel word to serialize.
- in_dir  in  1  0 = left shift, 1 = right shift.
- en  out  1  shift enable to the register.
- dir  out  1  direction to the register.
- d  out  1  serial bit to the register.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse after the last shifted bit.
- parity  out  1  even parity of the last accepted word. Present only when SER_PARITY_EN is defined.

## Operation
- States:
  - IDLE: waiting for a word.
  - SHIFT: SIZE bits being issued.
  - DONE: single-cycle completion.
- Handshake: `in_ready = (state != SHIFT)`. A transfer occurs on a rising edge with `in_valid && in_ready`.
- On a transfer:
  - latch `in_data` into a shadow register and `in_dir` into `dir`;
  - clear the bit counter;
  - go to SHIFT.
- Bit order:
  - dir=0: MSB first. Bits enter at the LSB and move toward the MSB.
  - dir=1: LSB first. Bits enter at the MSB and move toward the LSB.
  - In both cases the register holds the word after SIZE shifts.
- SHIFT:
  - `en`=1 and `d` = current bit.
  - The counter increments each cycle.
  - When the counter reaches SIZE-1, go to DONE.
- DONE:
  - `en`=0, `done`=1, `in_ready`=1.
  - A transfer in DONE goes straight to SHIFT (back-to-back frames with a one-cycle gap).
  - Otherwise go to IDLE.
- IDLE: `en`=0, `d`=0. `dir` holds its last value.
- Changes on `in_data`/`in_dir` during SHIFT are ignored. `in_valid` held during SHIFT is not consumed.
- Counter width is $clog2(SIZE). The SHIFT→DONE compare uses SIZE-1 exactly, with no wrap into extra bits.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; `en`, `dir`, `d`, `busy`, `done`, `parity` = 0; `in_ready`=1.
  - Any in-flight word is dropped.
  - After release, the first transfer is possible on the next rising edge.
- All outputs are registered except `in_ready` and `busy`, which decode the state.
- Transfer at edge T0:
  - `en`=1 from T0 through T0+SIZE (SIZE cycles); the register samples at edges T1..TSIZE.
  - `done`=1 during the cycle following edge TSIZE.
  - Downstream `out` equals the word after edge TSIZE.
- `busy` = (state == SHIFT).
- Throughput: one word per SIZE+1 cycles.

## Configuration
- SER_PARITY_EN
  - Defined: adds the `parity` output, equal to the registered XOR-reduction of the word, updated at the transfer edge and held until the next transfer.
  - Undefined: the port and its logic are absent, and the frame timing is identical.

## Structure
- Package `bidir_shift_pkg` holds:
  - the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the default SIZE;
  - the direction constants DIR_LEFT=0 and DIR_RIGHT=1.
- One sub-module, `shift_bit_counter`, is parameterized by SIZE. It has inputs `clr` and `inc` and outputs `cnt` and `last`.
- The FSM, shadow register and bit mux live in the top level.

## Test plan
- SIZE=16, word 16'hA5C3, dir=0:
  - `d` sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 with `en` high for 16 cycles;
  - `done` pulses on the next cycle;
  - a connected register reads 16'hA5C3.
- Same word, dir=1: `d` sequence is LSB first (1,1,0,0,0,0,1,1,…) and the register reads 16'hA5C3.
- `in_valid` held continuously with two words 16'h0001 then 16'h8000: the second is accepted in the DONE cycle, leaving exactly one `en`=0 gap between frames.
- `rst` driven low at bit 7 of a frame: all outputs are 0 immediately, `in_ready`=1, and a new word after release serializes correctly from bit 0.
- `in_data` toggled during SHIFT: the serialized bits match the latched word, and `in_valid` is ignored until DONE.
- With SER_PARITY_EN: word 16'h0007 gives `parity`=1 and 16'h0003 gives `parity`=0; without the macro, the frame timing is unchanged.

Source files
------------

// File: rtl/bidir_shift_feeder_pkg.sv
// Shared constants for the bidirectional shift register feeder.
// The optional parity output is enabled by defining SER_PARITY_EN.
package bidir_shift_pkg;

  localparam int DEFAULT_SIZE = 16;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bidir_shift_feeder_counter.sv
// Bit counter for one serial frame: cleared when a word is accepted, counts
// the bits issued, and flags the final bit position (SIZE-1).
module shift_bit_counter
  import bidir_shift_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    inc,
  output logic [$clog2(SIZE)-1:0] cnt,
  output logic                    last
);

  localparam int              CW   = $clog2(SIZE);
  localparam logic [CW-1:0]   LAST = CW'(SIZE - 1);

  logic [CW-1:0] r_cnt;

  // clear takes priority so a new frame always starts at bit 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign cnt  = r_cnt;
  assign last = (r_cnt == LAST);

endmodule

// File: rtl/bidir_shift_feeder.sv
// Serializer feeding a bidirectional shift register. A word accepted over
// valid/ready is shifted out over exactly SIZE enabled clocks, ordered so the
// register holds the word afterwards in either direction, then done pulses.
// Defining SER_PARITY_EN adds a registered even-parity output of the word.
//
// state | meaning
// IDLE  | waiting for a word; en=0, d=0, dir holds
// SHIFT | SIZE bits being issued, en=1
// DONE  | one-cycle completion, done=1, can accept the next word
module bidir_shift_feeder
  import bidir_shift_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_dir,
  output logic            en,
  output logic            dir,
  output logic            d,
  output logic            busy,
  output logic            done
`ifdef SER_PARITY_EN
  ,
  output logic            parity
`endif
);

  localparam int            CW   = $clog2(SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  state_t          r_state;
  logic [SIZE-1:0] r_word;
  logic            r_en;
  logic            r_dir;
  logic            r_d;
  logic            r_done;

  logic            w_xfer;
  logic            w_inc;
  logic            w_last;
  logic [CW-1:0]   w_cnt;
  logic [CW-1:0]   w_nxt_cnt;
  logic [CW-1:0]   w_nxt_idx;
  logic            w_nxt_bit;
  logic            w_first_bit;

  assign in_ready = (r_state != ST_SHIFT);
  assign busy     = (r_state == ST_SHIFT);
  assign w_xfer   = in_valid && in_ready;
  assign w_inc    = busy && !w_last;

  // Left shifts enter at the LSB, so the MSB must go first; right shifts
  // enter at the MSB, so the LSB goes first.
  assign w_nxt_cnt   = w_cnt + CW'(1);
  assign w_nxt_idx   = (r_dir == DIR_RIGHT) ? w_nxt_cnt : (LAST - w_nxt_cnt);
  assign w_nxt_bit   = r_word[w_nxt_idx];
  assign w_first_bit = (in_dir == DIR_RIGHT) ? in_data[0] : in_data[SIZE-1];

  shift_bit_counter #(
    .SIZE (SIZE)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_xfer),
    .inc  (w_inc),
    .cnt  (w_cnt),
    .last (w_last)
  );

  // frame sequencing; d is registered one bit ahead of the counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
      r_en    <= 1'b0;
      r_dir   <= DIR_LEFT;
      r_d     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_xfer) begin
            r_state <= ST_SHIFT;
            r_word  <= in_data;
            r_dir   <= in_dir;
            r_en    <= 1'b1;
            r_d     <= w_first_bit;
          end else begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_d     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_en    <= 1'b0;
            r_d     <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_d <= w_nxt_bit;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_en    <= 1'b0;
          r_d     <= 1'b0;
        end
      endcase
    end
  end

  assign en   = r_en;
  assign dir  = r_dir;
  assign d    = r_d;
  assign done = r_done;

`ifdef SER_PARITY_EN
  logic r_parity;

  // parity follows the accepted word and holds until the next transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_parity <= 1'b0;
    end else if (w_xfer) begin
      r_parity <= ^in_data;
    end
  end

  assign parity = r_parity;
`endif

endmodule

// File: tb/tb_bidir_shift_feeder.sv
// Directed bench for bidir_shift_feeder, with a behavioural downstream
// shift register. Build with SER_PARITY_EN defined to cover the parity port.
module tb_bidir_shift_feeder;

  localparam int SIZE = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [SIZE-1:0] in_data = '0;
  logic            in_dir = 1'b0;
  logic            en;
  logic            dir;
  logic            d;
  logic            busy;
  logic            done;
`ifdef SER_PARITY_EN
  logic            parity;
`endif

  int errors = 0;
  int checks = 0;

  logic [SIZE-1:0] ds_out = '0;

  bidir_shift_feeder #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dir   (in_dir),
    .en       (en),
    .dir      (dir),
    .d        (d),
    .busy     (busy),
    .done     (done)
`ifdef SER_PARITY_EN
    ,
    .parity   (parity)
`endif
  );

  always #5 clk = ~clk;

  // downstream bidirectional shift register
  always @(posedge clk) begin
    if (en) ds_out <= dir ? {d, ds_out[SIZE-1:1]} : {ds_out[SIZE-2:0], d};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic offer(input logic [15:0] word, input logic wdir);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = word;
    in_dir   = wdir;
    @(posedge clk);
  endtask

  // samples the 16 bit cycles following a transfer edge
  // mode 0: drop valid, 1: hold valid and present next_data, 2: scramble data
  task automatic capture_frame(input int mode, input logic [15:0] next_data,
                               output logic [15:0] seq, output int en_cnt,
                               output int busy_cnt, output int rdy_cnt);
    seq = '0; en_cnt = 0; busy_cnt = 0; rdy_cnt = 0;
    for (int k = 0; k < SIZE; k++) begin
      @(negedge clk);
      seq[k] = d;
      if (en) en_cnt++;
      if (busy) busy_cnt++;
      if (in_ready) rdy_cnt++;
      case (mode)
        0: if (k == 0) in_valid = 1'b0;
        1: if (k == 0) in_data = next_data;
        default: begin
          in_data = 16'($urandom);
          if (k == SIZE - 1) in_valid = 1'b0;
        end
      endcase
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", en); end
    checks++; if (d !== 1'b0) begin errors++; $display("FAIL reset_d: got %b expected 0", d); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b expected 0", dir); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
`ifdef SER_PARITY_EN
    checks++; if (parity !== 1'b0) begin errors++; $display("FAIL reset_parity: got %b expected 0", parity); end
`endif
    in_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_left();
    logic [15:0] seq; int ec, bc, rc;
    offer(16'hA5C3, 1'b0);
    capture_frame(0, 16'h0, seq, ec, bc, rc);
    checks++; if (seq !== 16'hC3A5) begin errors++; $display("FAIL left_seq: got %h expected c3a5 (bit k = k-th d)", seq); end
    checks++; if (ec !== 16) begin errors++; $display("FAIL left_en_cycles: got %0d expected 16", ec); end
    checks++; if (bc !== 16) begin errors++; $display("FAIL left_busy_cycles: got %0d expected 16", bc); end
    checks++; if (rc !== 0) begin errors++; $display("FAIL left_ready_in_shift: got %0d expected 0", rc); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL left_done: got %b expected 1", done); end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL left_done_en: got %b expected 0", en); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL left_done_ready: got %b expected 1", in_ready); end
    checks++; if (ds_out !== 16'hA5C3) begin errors++; $display("FAIL left_register: got %h expected a5c3", ds_out); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL left_done_pulse: got %b expected 0", done); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL left_dir: got %b expected 0", dir); end
  endtask

  task automatic test_right();
    logic [15:0] seq; int ec, bc, rc;
    offer(16'hA5C3, 1'b1);
    capture_frame(0, 16'h0, seq, ec, bc, rc);
    checks++; if (seq !== 16'hA5C3) begin errors++; $display("FAIL right_seq: got %h expected a5c3 (bit k = k-th d)", seq); end
    checks++; if (ec !== 16) begin errors++; $display("FAIL right_en_cycles: got %0d expected 16", ec); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL right_done: got %b expected 1", done); end
    checks++; if (ds_out !== 16'hA5C3) begin errors++; $display("FAIL right_register: got %h expected a5c3", ds_out); end
    @(negedge clk);
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL right_dir_hold: got %b expected 1", dir); end
    checks++; if (d !== 1'b0) begin errors++; $display("FAIL right_idle_d: got %b expected 0", d); end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL right_idle_en: got %b expected 0", en); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq; int ec, bc, rc;
    offer(16'h0001, 1'b0);
    capture_frame(1, 16'h8000, seq, ec, bc, rc);
    checks++; if (seq !== 16'h8000) begin errors++; $display("FAIL b2b_seq1: got %h expected 8000", seq); end
    checks++; if (rc !== 0) begin errors++; $display("FAIL b2b_ready_in_shift: got %0d expected 0", rc); end
    @(negedge clk);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL b2b_gap_en: got %b expected 0", en); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b expected 1", done); end
    checks++; if (ds_out !== 16'h0001) begin errors++; $display("FAIL b2b_register1: got %h expected 0001", ds_out); end
    @(posedge clk);
    capture_frame(0, 16'h0, seq, ec, bc, rc);
    checks++; if (seq !== 16'h0001) begin errors++; $display("FAIL b2b_seq2: got %h expected 0001", seq); end
    checks++; if (ec !== 16) begin errors++; $display("FAIL b2b_en_cycles2: got %0d expected 16", ec); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b expected 1", done); end
    checks++; if (ds_out !== 16'h8000) begin errors++; $display("FAIL b2b_register2: got %h expected 8000", ds_out); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] seq; int ec, bc, rc;
    offer(16'h1234, 1'b1);
    seq = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seq[k] = d;
      if (k == 0) in_valid = 1'b0;
    end
    checks++; if (seq[7:0] !== 8'h34) begin errors++; $display("FAIL rstmid_pre_bits: got %h expected 34", seq[7:0]); end
    #2 rst = 1'b0;
    #1;
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL rstmid_en: got %b expected 0", en); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL rstmid_dir: got %b expected 0", dir); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h3C5A;
    in_dir   = 1'b0;
    @(posedge clk);
    capture_frame(0, 16'h0, seq, ec, bc, rc);
    checks++; if (seq !== 16'h5A3C) begin errors++; $display("FAIL rstmid_seq: got %h expected 5a3c", seq); end
    checks++; if (ec !== 16) begin errors++; $display("FAIL rstmid_en_cycles: got %0d expected 16", ec); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done: got %b expected 1", done); end
    checks++; if (ds_out !== 16'h3C5A) begin errors++; $display("FAIL rstmid_register: got %h expected 3c5a", ds_out); end
    @(negedge clk);
  endtask

  task automatic test_data_toggle();
    logic [15:0] seq; int ec, bc, rc;
    offer(16'h0F0F, 1'b1);
    capture_frame(2, 16'h0, seq, ec, bc, rc);
    checks++; if (seq !== 16'h0F0F) begin errors++; $display("FAIL toggle_seq: got %h expected 0f0f", seq); end
    checks++; if (bc !== 16) begin errors++; $display("FAIL toggle_busy_cycles: got %0d expected 16", bc); end
    checks++; if (rc !== 0) begin errors++; $display("FAIL toggle_ready_in_shift: got %0d expected 0", rc); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL toggle_done: got %b expected 1", done); end
    checks++; if (ds_out !== 16'h0F0F) begin errors++; $display("FAIL toggle_register: got %h expected 0f0f", ds_out); end
    @(negedge clk);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL toggle_idle_en: got %b expected 0", en); end
  endtask

  task automatic test_parity();
    logic [15:0] seq; int ec, bc, rc;
    offer(16'h0007, 1'b0);
    capture_frame(0, 16'h0, seq, ec, bc, rc);
    checks++; if (ec !== 16) begin errors++; $display("FAIL par_en_cycles: got %0d expected 16", ec); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL par_done: got %b expected 1", done); end
`ifdef SER_PARITY_EN
    checks++; if (parity !== 1'b1) begin errors++; $display("FAIL par_0007: got %b expected 1", parity); end
`endif
    offer(16'h0003, 1'b1);
    capture_frame(0, 16'h0, seq, ec, bc, rc);
    checks++; if (seq !== 16'h0003) begin errors++; $display("FAIL par_seq: got %h expected 0003", seq); end
    @(negedge clk);
    checks++; if (ds_out !== 16'h0003) begin errors++; $display("FAIL par_register: got %h expected 0003", ds_out); end
`ifdef SER_PARITY_EN
    checks++; if (parity !== 1'b0) begin errors++; $display("FAIL par_0003: got %b expected 0", parity); end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_left();
    test_right();
    test_back_to_back();
    test_reset_midframe();
    test_data_toggle();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
